// File: rtl/core_types_pkg.sv
// Shared dispatch-stage types: tag/checkpoint widths and ready-vector helpers.
// Imported by the ready table top and its checkpoint bank.
package core_types_pkg;
  localparam int NUM_PHYS_REGS = 64;
  localparam int NUM_ARCH_REGS = 32;
  localparam int DEFAULT_DISPATCH_WIDTH = 2;
  localparam int DEFAULT_NUM_COMPLETE_BUSES = 3;
  localparam int DEFAULT_NUM_CHECKPOINTS = 4;
  localparam int TAG_W = $clog2(NUM_PHYS_REGS);
  localparam int CKPT_W = $clog2(DEFAULT_NUM_CHECKPOINTS);

  typedef logic [TAG_W-1:0] phys_reg_tag_t;
  typedef logic [CKPT_W-1:0] checkpoint_index_t;
  typedef logic [NUM_PHYS_REGS-1:0] ready_vec_t;

  localparam ready_vec_t RESET_READY = {
    {(NUM_PHYS_REGS-NUM_ARCH_REGS){1'b0}},
    {NUM_ARCH_REGS{1'b1}}
  };

  function automatic ready_vec_t tag_onehot(phys_reg_tag_t t);
    return ready_vec_t'(1) << t;
  endfunction
endpackage

// File: rtl/ready_table_checkpoint_bank.sv
// Snapshot slots of the ready table with valid bits; saves, keeps
// snapshots current with completes, and presents the restore slot.
module ready_table_checkpoint_bank
  import core_types_pkg::*;
#(
  parameter int NUM_CHECKPOINTS = DEFAULT_NUM_CHECKPOINTS,
  localparam int CW = $clog2(NUM_CHECKPOINTS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          save,
  input  logic [CW-1:0] save_index,
  input  ready_vec_t    save_data,
  input  ready_vec_t    complete_mask,
  input  logic [CW-1:0] restore_index,
  output logic          restore_hit,
  output ready_vec_t    restore_data
);
  ready_vec_t snap [NUM_CHECKPOINTS];
  logic [NUM_CHECKPOINTS-1:0] valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (save) begin
      valid[save_index] <= 1'b1;
    end
  end

  // Contents need no reset: a slot is only read once valid.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CHECKPOINTS; k++) begin
      if (save && save_index == CW'(k)) begin
        snap[k] <= save_data;
      end else if (valid[k]) begin
        snap[k] <= snap[k] | complete_mask;
      end
    end
  end

  assign restore_hit  = valid[restore_index];
  assign restore_data = snap[restore_index];
endmodule

// File: rtl/phys_reg_ready_table_mw.sv
// Multi-way physical register ready table: live table, per-way
// forwarding chain, checkpoint save/restore control and error pulse.
module phys_reg_ready_table_mw
  import core_types_pkg::*;
#(
  parameter int DISPATCH_WIDTH = DEFAULT_DISPATCH_WIDTH,
  parameter int NUM_COMPLETE_BUSES = DEFAULT_NUM_COMPLETE_BUSES,
  parameter int NUM_CHECKPOINTS = DEFAULT_NUM_CHECKPOINTS,
  localparam int DW = DISPATCH_WIDTH * TAG_W,
  localparam int BW = NUM_COMPLETE_BUSES * TAG_W,
  localparam int CW = $clog2(NUM_CHECKPOINTS)
) (
  input  logic                      CLK,
  input  logic                      RST,
  output logic                      DUT_error,
  input  logic [DW-1:0]             dispatch_source_0_phys_reg_tag,
  output logic [DISPATCH_WIDTH-1:0] dispatch_source_0_ready,
  input  logic [DW-1:0]             dispatch_source_1_phys_reg_tag,
  output logic [DISPATCH_WIDTH-1:0] dispatch_source_1_ready,
  input  logic [DISPATCH_WIDTH-1:0] dispatch_dest_write,
  input  logic [DW-1:0]             dispatch_dest_phys_reg_tag,
  input  logic [NUM_COMPLETE_BUSES-1:0] complete_bus_valid,
  input  logic [BW-1:0]             complete_bus_dest_phys_reg_tag,
  input  logic                      checkpoint_save_valid,
  input  logic [CW-1:0]             checkpoint_save_index,
  input  logic                      checkpoint_restore_valid,
  input  logic [CW-1:0]             checkpoint_restore_index
);
  ready_vec_t tbl;
  ready_vec_t comp_mask;
  ready_vec_t clr_acc;
  ready_vec_t avail;
  ready_vec_t normal_next;
  ready_vec_t next_tbl;
  ready_vec_t restore_data;
  logic restore_hit;
  logic err;
  phys_reg_tag_t t0, t1, td, tc;

  always_comb begin
    err = 1'b0;
    comp_mask = '0;
    clr_acc = '0;
    avail = '0;
    t0 = '0;
    t1 = '0;
    td = '0;
    tc = '0;
    dispatch_source_0_ready = '0;
    dispatch_source_1_ready = '0;
    for (int b = 0; b < NUM_COMPLETE_BUSES; b++) begin
      tc = complete_bus_dest_phys_reg_tag[b*TAG_W +: TAG_W];
      if (complete_bus_valid[b]) begin
        if (tc == '0) begin
          err = 1'b1;
        end else begin
          if (comp_mask[tc]) err = 1'b1;
          comp_mask = comp_mask | tag_onehot(tc);
        end
      end
    end
    // Each way sees completes plus clears of strictly older ways.
    for (int w = 0; w < DISPATCH_WIDTH; w++) begin
      t0 = dispatch_source_0_phys_reg_tag[w*TAG_W +: TAG_W];
      t1 = dispatch_source_1_phys_reg_tag[w*TAG_W +: TAG_W];
      td = dispatch_dest_phys_reg_tag[w*TAG_W +: TAG_W];
      avail = (tbl | comp_mask) & ~clr_acc;
      dispatch_source_0_ready[w] = (t0 == '0) || avail[t0];
      dispatch_source_1_ready[w] = (t1 == '0) || avail[t1];
      if (dispatch_dest_write[w]) begin
        if (td == '0) begin
          err = 1'b1;
        end else begin
          if (clr_acc[td] || comp_mask[td]) err = 1'b1;
          clr_acc = clr_acc | tag_onehot(td);
        end
      end
    end
    if (checkpoint_restore_valid &&
        (checkpoint_save_valid || !restore_hit ||
         (|dispatch_dest_write))) begin
      err = 1'b1;
    end
    normal_next = (tbl | comp_mask) & ~clr_acc;
    if (checkpoint_restore_valid && restore_hit) begin
      next_tbl = restore_data | comp_mask;
    end else begin
      next_tbl = normal_next;
    end
  end

  ready_table_checkpoint_bank #(
    .NUM_CHECKPOINTS(NUM_CHECKPOINTS)
  ) u_bank (
    .clk           (CLK),
    .rst           (RST),
    .save          (checkpoint_save_valid && !checkpoint_restore_valid),
    .save_index    (checkpoint_save_index),
    .save_data     (normal_next),
    .complete_mask (comp_mask),
    .restore_index (checkpoint_restore_index),
    .restore_hit   (restore_hit),
    .restore_data  (restore_data)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tbl       <= RESET_READY;
      DUT_error <= 1'b0;
    end else begin
      tbl       <= next_tbl;
      DUT_error <= err;
    end
  end
endmodule

// File: tb/tb_phys_reg_ready_table_mw.sv
// Randomized and directed checks of the multi-way ready table
// against a sequential event-by-event reference model.
module tb_phys_reg_ready_table_mw;
  localparam int W = 2;
  localparam int B = 3;

  logic CLK = 1'b0;
  logic RST;
  logic DUT_error;
  logic [5:0] s0 [W];
  logic [5:0] s1 [W];
  logic [5:0] dt [W];
  logic [5:0] ct [B];
  logic [W-1:0] dw;
  logic [B-1:0] cv;
  logic sv, rv;
  logic [1:0] si, ri;
  logic [W-1:0] r0, r1;

  int checks = 0;
  int fails = 0;

  bit [63:0] m_tbl;
  bit [63:0] m_snap [4];
  bit [3:0]  m_val;
  bit [63:0] m_comp, m_norm;
  bit [W-1:0] e_r0, e_r1;
  bit e_err;

  phys_reg_ready_table_mw dut (
    .CLK(CLK),
    .RST(RST),
    .DUT_error(DUT_error),
    .dispatch_source_0_phys_reg_tag({s0[1], s0[0]}),
    .dispatch_source_0_ready(r0),
    .dispatch_source_1_phys_reg_tag({s1[1], s1[0]}),
    .dispatch_source_1_ready(r1),
    .dispatch_dest_write(dw),
    .dispatch_dest_phys_reg_tag({dt[1], dt[0]}),
    .complete_bus_valid(cv),
    .complete_bus_dest_phys_reg_tag({ct[2], ct[1], ct[0]}),
    .checkpoint_save_valid(sv),
    .checkpoint_save_index(si),
    .checkpoint_restore_valid(rv),
    .checkpoint_restore_index(ri)
  );

  always #5 CLK = ~CLK;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    for (int w = 0; w < W; w++) begin
      s0[w] = 6'd0; s1[w] = 6'd0; dt[w] = 6'd0;
    end
    for (int b = 0; b < B; b++) ct[b] = 6'd0;
    dw = '0; cv = '0;
    sv = 1'b0; rv = 1'b0; si = 2'd0; ri = 2'd0;
  endtask

  task automatic model_reset();
    m_tbl = {32'h0, 32'hFFFF_FFFF};
    m_val = '0;
  endtask

  // Walk events in time order: completes, then each way reads
  // and then clears.
  task automatic eval();
    bit [63:0] cur;
    int ccnt [64];
    int dcnt [64];
    for (int t = 0; t < 64; t++) begin
      ccnt[t] = 0; dcnt[t] = 0;
    end
    e_err = 1'b0;
    m_comp = '0;
    cur = m_tbl;
    for (int b = 0; b < B; b++) begin
      if (cv[b]) begin
        if (ct[b] == 0) e_err = 1'b1;
        else begin
          cur[ct[b]] = 1'b1;
          m_comp[ct[b]] = 1'b1;
          ccnt[ct[b]]++;
        end
      end
    end
    for (int w = 0; w < W; w++) begin
      e_r0[w] = (s0[w] == 0) || cur[s0[w]];
      e_r1[w] = (s1[w] == 0) || cur[s1[w]];
      if (dw[w]) begin
        if (dt[w] == 0) e_err = 1'b1;
        else begin
          cur[dt[w]] = 1'b0;
          dcnt[dt[w]]++;
        end
      end
    end
    for (int t = 1; t < 64; t++) begin
      if (ccnt[t] > 1 || dcnt[t] > 1) e_err = 1'b1;
      if (ccnt[t] > 0 && dcnt[t] > 0) e_err = 1'b1;
    end
    if (rv && (!m_val[ri] || sv || dw != 0)) e_err = 1'b1;
    m_norm = cur;
  endtask

  task automatic model_edge();
    if (rv && m_val[ri]) m_tbl = m_snap[ri] | m_comp;
    else m_tbl = m_norm;
    for (int k = 0; k < 4; k++) begin
      if (sv && !rv && si == 2'(k)) begin
        m_snap[k] = m_norm;
        m_val[k] = 1'b1;
      end else if (m_val[k]) begin
        m_snap[k] = m_snap[k] | m_comp;
      end
    end
  endtask

  task automatic cyc();
    #1;
    eval();
    chk("rd_src0", r0, e_r0);
    chk("rd_src1", r1, e_r1);
    @(posedge CLK);
    model_edge();
    #1;
    chk("err", DUT_error, e_err);
  endtask

  task automatic peek2(logic [5:0] a, logic [5:0] b,
                       logic ea, logic eb);
    idle();
    s0[0] = a; s0[1] = b;
    #1;
    chk("peek_a", r0[0], ea);
    chk("peek_b", r0[1], eb);
  endtask

  function automatic logic [5:0] rtag();
    if ($urandom_range(0, 15) == 0) return 6'd0;
    if ($urandom_range(0, 1) == 1) return 6'($urandom_range(1, 8));
    return 6'($urandom_range(32, 40));
  endfunction

  initial begin
    idle();
    RST = 1'b1;
    model_reset();
    #2;
    chk("rst_err", DUT_error, 1'b0);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // 1: reset pattern
    peek2(6'd5, 6'd40, 1'b1, 1'b0);
    chk("rst_err2", DUT_error, 1'b0);
    idle();
    cyc();

    // 2: intra-bundle forwarding with complete/clear conflict
    idle();
    dw[0] = 1'b1; dt[0] = 6'd40;
    s0[0] = 6'd40; s0[1] = 6'd40;
    cv[1] = 1'b1; ct[1] = 6'd40;
    #1;
    chk("fwd_w1", r0[1], 1'b0);
    chk("fwd_w0", r0[0], 1'b1);
    cyc();
    chk("fwd_err", DUT_error, 1'b1);
    peek2(6'd40, 6'd0, 1'b0, 1'b1);
    cyc();

    // 3: complete forwarding
    idle();
    cv[2] = 1'b1; ct[2] = 6'd33;
    s1[0] = 6'd33;
    #1;
    chk("cfwd", r1[0], 1'b1);
    cyc();
    peek2(6'd33, 6'd33, 1'b1, 1'b1);
    cyc();

    // 4: save, later clear, complete, restore
    idle();
    sv = 1'b1; si = 2'd2; dw[0] = 1'b1; dt[0] = 6'd34;
    cyc();
    idle();
    dw[0] = 1'b1; dt[0] = 6'd35;
    cyc();
    idle();
    cv[0] = 1'b1; ct[0] = 6'd34;
    cyc();
    idle();
    rv = 1'b1; ri = 2'd2;
    cyc();
    chk("rest_err", DUT_error, 1'b0);
    peek2(6'd34, 6'd35, 1'b1, 1'b0);
    cyc();

    // 5: restore invalid slot; save+restore collision
    idle();
    rv = 1'b1; ri = 2'd3;
    cyc();
    chk("bad_rest", DUT_error, 1'b1);
    idle();
    sv = 1'b1; si = 2'd1; rv = 1'b1; ri = 2'd2;
    cyc();
    chk("sv_rv", DUT_error, 1'b1);
    idle();
    rv = 1'b1; ri = 2'd1;
    cyc();

    // 6: reset during a restore cycle
    idle();
    rv = 1'b1; ri = 2'd2;
    #2;
    RST = 1'b1;
    model_reset();
    idle();
    #1;
    chk("mid_rst_err", DUT_error, 1'b0);
    chk("mid_rst_r5", r0[0], 1'b1);
    s0[1] = 6'd34;
    #1;
    chk("mid_rst_r34", r0[1], 1'b0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    idle();
    rv = 1'b1; ri = 2'd2;
    cyc();
    chk("ckpt_cleared", DUT_error, 1'b1);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      idle();
      for (int w = 0; w < W; w++) begin
        s0[w] = rtag(); s1[w] = rtag(); dt[w] = rtag();
        dw[w] = ($urandom_range(0, 1) == 1);
      end
      for (int b = 0; b < B; b++) begin
        ct[b] = rtag();
        cv[b] = ($urandom_range(0, 2) == 0);
      end
      sv = ($urandom_range(0, 5) == 0);
      si = 2'($urandom_range(0, 3));
      rv = ($urandom_range(0, 7) == 0);
      ri = 2'($urandom_range(0, 3));
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/phys_reg_ready_table_mw.md
Name: phys_reg_ready_table_mw

Overview:
Parametrised successor to the dispatch-stage physical register ready table. It serves DISPATCH_WIDTH dispatch ways, with intra-bundle dependency forwarding, and NUM_COMPLETE_BUSES complete buses. It also holds NUM_CHECKPOINTS ready-table snapshots that can be saved on branch dispatch and restored on mispredict. Sits in dispatch_unit alongside the rename map table and free list, and shares their checkpoint indices.

Parameters:
NUM_PHYS_REGS, 64, physical register count (power of 2)
NUM_ARCH_REGS, 32, phys regs ready out of reset (tags 0..NUM_ARCH_REGS-1)
DISPATCH_WIDTH, 2, dispatch ways per cycle; way 0 is oldest
NUM_COMPLETE_BUSES, 3, complete buses (ALU0, ALU1, LQ by default)
NUM_CHECKPOINTS, 4, snapshot slots (power of 2)

Ports:
CLK  in  1  clock
RST  in  1  asynchronous reset, active-high
DUT_error  out  1  registered error pulse
dispatch_source_0_phys_reg_tag  in  DISPATCH_WIDTH*TAG_W  per-way source 0 tag
dispatch_source_0_ready  out  DISPATCH_WIDTH  per-way source 0 ready (comb)
dispatch_source_1_phys_reg_tag  in  DISPATCH_WIDTH*TAG_W  per-way source 1 tag
dispatch_source_1_ready  out  DISPATCH_WIDTH  per-way source 1 ready (comb)
dispatch_dest_write  in  DISPATCH_WIDTH  per-way clear request
dispatch_dest_phys_reg_tag  in  DISPATCH_WIDTH*TAG_W  per-way dest tag
complete_bus_valid  in  NUM_COMPLETE_BUSES  per-bus set request
complete_bus_dest_phys_reg_tag  in  NUM_COMPLETE_BUSES*TAG_W  per-bus dest tag
checkpoint_save_valid  in  1  snapshot request
checkpoint_save_index  in  CKPT_W  snapshot slot
checkpoint_restore_valid  in  1  restore request
checkpoint_restore_index  in  CKPT_W  restore slot

Behaviour:
- Reset (RST=1, async):
  - table bits 0..NUM_ARCH_REGS-1 = 1, all other bits = 0
  - all checkpoint valid bits = 0; snapshot contents are don't-care
  - DUT_error = 0
- Normal cycle, next table:
  - Start from the current table.
  - Set the bit for every valid complete bus.
  - Then clear the bit for every dispatch way with dest_write=1, applied in way order.
- Tag 0 handling:
  - Writes to tag 0 from any dispatch way or complete bus are ignored and raise an error.
  - Reads of tag 0 always return ready=1.
- Read for way w:
  - Value = current table with all completes applied and the clears from ways 0..w-1 applied.
  - A way's own dest clear never affects its own sources.
  - The same-cycle complete forward is preserved (a value completing now reads as ready).
- Write conflicts:
  - Complete vs dispatch clear on the same tag: the clear wins, and an error is raised.
  - Two completes on the same tag: harmless set, but an error is still raised.
  - Two dispatch ways clearing the same tag: error raised.
- Checkpoint save (save_valid=1, restore_valid=0):
  - snapshot[save_index] <= this cycle's next table, including all of this cycle's ways.
  - valid[save_index] <= 1; an existing snapshot in that slot is overwritten.
- Snapshot maintenance: every cycle, each valid snapshot not being written also sets the bits of that cycle's valid completes. A restored snapshot therefore reflects completions that happened after the save.
- Restore (restore_valid=1, valid[restore_index]=1):
  - next table = snapshot[restore_index] | this cycle's completes.
  - All dispatch clears in that cycle are ignored.
  - Read outputs still follow the normal-cycle rule.
  - The slot stays valid.
- Restore to an invalid slot: ignored (normal cycle proceeds) and an error is raised.
- Save and restore in the same cycle: restore wins, save is dropped, error raised.
- Dispatch dest_write during a restore cycle: clear dropped, error raised.
- DUT_error timing: registered; high exactly the cycle after any error condition, low otherwise. Non-fatal.
- Latency: sets and clears are visible in the table one cycle later and forwarded combinationally in the same cycle. Restore takes effect on the next edge.

Decomposition:
- core_types_pkg provides:
  - phys_reg_tag_t (TAG_W = $clog2(NUM_PHYS_REGS))
  - checkpoint_index_t (CKPT_W = $clog2(NUM_CHECKPOINTS))
  - NUM_PHYS_REGS, NUM_ARCH_REGS
  - default DISPATCH_WIDTH, NUM_COMPLETE_BUSES, NUM_CHECKPOINTS
- One sub-module: ready_table_checkpoint_bank. It holds the snapshots and valid bits, with save, complete-set and restore-read logic.
- The top holds the live table, the way-ordered forwarding chain and the error logic.

Test Plan:
1. Out of reset: read tags 5, 40 -> ready 1, 0; DUT_error=0.
2. Intra-bundle forwarding:
   - Stimulus: way0 dest=40, way1 src0=40, complete bus1 tag=40 same cycle.
   - Response: way1 src0 ready=0, way0 sources unaffected, bit 40 = 0 next cycle, DUT_error=1 next cycle.
3. Complete forwarding: bus2 tag=33 valid, way0 src1=33 same cycle -> ready=1; bit 33 = 1 next cycle.
4. Save, then restore with a complete in between:
   - Save slot 2 with way0 dest=34.
   - Next cycle, way0 dest=35.
   - Cycle after, bus0 completes 34.
   - Then restore slot 2.
   - Required: bit 34 = 1, bit 35 = 0 (pre-save value), no error.
5. Error cases:
   - Restore slot 3 (never saved) -> table unchanged, DUT_error pulse.
   - Save + restore same cycle -> restore applied, save dropped, error pulse.
6. Reset mid-operation: assert RST during a restore cycle -> table returns to the reset pattern, all checkpoints invalid, DUT_error=0.
